// File: rtl/buffered_matrixn_colorspace_converter_if.sv
// Video pixel stream in, NxN grayscale window out.
// Matrix width depends on CENTER_PIXEL_EN (centre slot included when defined).
interface buffered_matrixn_colorspace_converter_if #(
  parameter int P_FRAME_COLUMNS = 640,
  parameter int P_FRAME_ROWS    = 480,
  parameter int P_PIXEL_DEPTH   = 24,
  parameter int P_MATRIX_SIZE   = 3
);
  localparam int D = P_PIXEL_DEPTH / 3;
`ifdef CENTER_PIXEL_EN
  localparam int P_MATRIX_BITS = D * P_MATRIX_SIZE * P_MATRIX_SIZE;
`else
  localparam int P_MATRIX_BITS = D * (P_MATRIX_SIZE * P_MATRIX_SIZE - 1);
`endif
  localparam int COL_W = $clog2(P_FRAME_COLUMNS);
  localparam int ROW_W = $clog2(P_FRAME_ROWS);

  logic [P_PIXEL_DEPTH-1:0] pixel;
  logic                     vsync;
  logic                     data_enable;
  logic [COL_W-1:0]         pixel_column;
  logic [ROW_W-1:0]         pixel_row;
  logic [P_MATRIX_BITS-1:0] pixel_matrix;
  logic                     pixel_matrix_ready;

  modport master (
    output pixel, vsync, data_enable,
    input  pixel_column, pixel_row, pixel_matrix, pixel_matrix_ready
  );

  modport slave (
    input  pixel, vsync, data_enable,
    output pixel_column, pixel_row, pixel_matrix, pixel_matrix_ready
  );
endinterface

// File: rtl/buffered_matrixn_colorspace_converter.sv
// RGB->gray converter with N-1 line buffers and an NxN window, one strobe per interior pixel.
// Define CENTER_PIXEL_EN to include the centre pixel in the emitted matrix.
module buffered_matrixn_colorspace_converter #(
  parameter int P_FRAME_COLUMNS = 640,
  parameter int P_FRAME_ROWS    = 480,
  parameter int P_PIXEL_DEPTH   = 24,
  parameter int P_MATRIX_SIZE   = 3,
  parameter int P_GRAY_MODE     = 0
) (
  input  logic clk,
  input  logic rst_n,
  buffered_matrixn_colorspace_converter_if.slave vid
);

  localparam int D      = P_PIXEL_DEPTH / 3;
  localparam int N      = P_MATRIX_SIZE;
  localparam int COL_W  = $clog2(P_FRAME_COLUMNS);
  localparam int CNT_W  = COL_W + 1;
  localparam int ROW_W  = $clog2(P_FRAME_ROWS);
  localparam int ROWC_W = ROW_W + 1;
  localparam int SUM_W  = D + 8;
  localparam int CTR    = (N * N) / 2;
`ifdef CENTER_PIXEL_EN
  localparam int E = N * N;
`else
  localparam int E = N * N - 1;
`endif
  localparam int P_MATRIX_BITS = D * E;

  typedef enum logic [1:0] {
    S_WAIT_FRAME,
    S_LINE_WAIT,
    S_LINE_ACTIVE
  } state_t;

  function automatic logic [D-1:0] to_gray(input logic [P_PIXEL_DEPTH-1:0] px);
    logic [SUM_W-1:0] r;
    logic [SUM_W-1:0] g;
    logic [SUM_W-1:0] b;
    logic [SUM_W-1:0] acc;
    r = SUM_W'(px[3*D-1:2*D]);
    g = SUM_W'(px[2*D-1:D]);
    b = SUM_W'(px[D-1:0]);
    if (P_GRAY_MODE == 0)
      acc = (r + g + b) * SUM_W'(85);
    else
      acc = r * SUM_W'(77) + g * SUM_W'(150) + b * SUM_W'(29);
    return acc[D+7:8];
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  col_cnt;
  logic [CNT_W-1:0]  col_nxt;
  logic [ROWC_W-1:0] row_cnt;
  logic [ROWC_W-1:0] row_nxt;
  logic              accept;
  logic              take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_WAIT_FRAME;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
    end
  end

  // VSYNC wins over everything, including a pixel presented in the same cycle.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    accept    = 1'b0;
    if (vid.vsync) begin
      state_nxt = S_LINE_WAIT;
      col_nxt   = '0;
      row_nxt   = '0;
    end else begin
      case (state)
        S_WAIT_FRAME: state_nxt = S_WAIT_FRAME;
        S_LINE_WAIT: begin
          if (vid.data_enable) begin
            accept    = 1'b1;
            state_nxt = S_LINE_ACTIVE;
          end
        end
        S_LINE_ACTIVE: begin
          if (vid.data_enable) begin
            accept = 1'b1;
          end else begin
            col_nxt   = '0;
            row_nxt   = row_cnt + ROWC_W'(1);
            state_nxt = (row_cnt == ROWC_W'(P_FRAME_ROWS - 1)) ? S_WAIT_FRAME : S_LINE_WAIT;
          end
        end
        default: state_nxt = S_WAIT_FRAME;
      endcase
      if (accept && (col_cnt < CNT_W'(P_FRAME_COLUMNS)))
        col_nxt = col_cnt + CNT_W'(1);
    end
  end

  assign take = accept && (col_cnt < CNT_W'(P_FRAME_COLUMNS));

  // ---- stage 1: gray conversion registered with its coordinates ----
  logic              vld_p1;
  logic [D-1:0]      gray_p1;
  logic [COL_W-1:0]  col_p1;
  logic [ROWC_W-1:0] row_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      gray_p1 <= '0;
      col_p1  <= '0;
      row_p1  <= '0;
    end else begin
      vld_p1 <= take;
      if (take) begin
        gray_p1 <= to_gray(vid.pixel);
        col_p1  <= col_cnt[COL_W-1:0];
        row_p1  <= row_cnt;
      end
    end
  end

  // ---- stage 2: line buffers, window shift, output register ----
  logic [D-1:0] lbuf    [N-1][P_FRAME_COLUMNS];
  logic [D-1:0] win     [N][N];
  logic [D-1:0] win_nxt [N][N];
  logic [D-1:0] col_new [N];
  logic [P_MATRIX_BITS-1:0] mat_nxt;
  logic         ready_nxt;

  // lbuf[0] holds the previous line, lbuf[N-2] the oldest; top window row comes from the oldest.
  for (genvar r = 0; r < N; r++) begin : g_col_new
    if (r == N - 1) begin : g_cur
      assign col_new[r] = gray_p1;
    end else begin : g_buf
      assign col_new[r] = lbuf[N-2-r][col_p1];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_wr
    for (genvar c = 0; c < N; c++) begin : g_wc
      localparam int IDX = r * N + c;
      if (c == N - 1) begin : g_right
        assign win_nxt[r][c] = col_new[r];
      end else begin : g_shift
        assign win_nxt[r][c] = win[r][c+1];
      end
`ifdef CENTER_PIXEL_EN
      assign mat_nxt[(E-1-IDX)*D +: D] = win_nxt[r][c];
`else
      if (IDX != CTR) begin : g_keep
        localparam int K = (IDX > CTR) ? IDX - 1 : IDX;
        assign mat_nxt[(E-1-K)*D +: D] = win_nxt[r][c];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N - 1; k++)
        for (int c = 0; c < P_FRAME_COLUMNS; c++)
          lbuf[k][c] <= '0;
    end else if (vld_p1) begin
      lbuf[0][col_p1] <= gray_p1;
      for (int k = 0; k < N - 2; k++)
        lbuf[k+1][col_p1] <= lbuf[k][col_p1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          win[r][c] <= '0;
    end else if (vld_p1) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          win[r][c] <= win_nxt[r][c];
    end
  end

  // Border pixels only fill the window; a line's first N-1 pixels flush the previous line out.
  assign ready_nxt = vld_p1 && (row_p1 >= ROWC_W'(N - 1)) && (col_p1 >= COL_W'(N - 1));

  logic                     ready_p2;
  logic [COL_W-1:0]         column_p2;
  logic [ROW_W-1:0]         row_p2;
  logic [P_MATRIX_BITS-1:0] matrix_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_p2  <= 1'b0;
      column_p2 <= '0;
      row_p2    <= '0;
      matrix_p2 <= '0;
    end else begin
      ready_p2 <= ready_nxt;
      if (ready_nxt) begin
        column_p2 <= col_p1 - COL_W'(N - 1);
        row_p2    <= ROW_W'(row_p1 - ROWC_W'(N - 1));
        matrix_p2 <= mat_nxt;
      end
    end
  end

  assign vid.pixel_matrix_ready = ready_p2;
  assign vid.pixel_column       = column_p2;
  assign vid.pixel_row          = row_p2;
  assign vid.pixel_matrix       = matrix_p2;

endmodule

// File: tb/tb_buffered_matrixn_colorspace_converter.sv
// Directed bench: 8x6 frames through N=3 mode 0, N=3 mode 1 and N=5 mode 0 converters.
// Optional CENTER_PIXEL_EN widens the expected matrices to include the centre pixel.
module tb_buffered_matrixn_colorspace_converter;

`ifdef CENTER_PIXEL_EN
  localparam bit CENTER = 1'b1;
`else
  localparam bit CENTER = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]   row;
    logic [7:0]   col;
    logic [255:0] mat;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pix = '0;
  logic        vsync = 1'b0;
  logic        de = 1'b0;
  int          total = 0;
  int          bad = 0;
  rec_t        q3[$];
  rec_t        q1[$];
  rec_t        q5[$];

  always #5 clk = ~clk;

  buffered_matrixn_colorspace_converter_if #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(6),
    .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(3)) if3 ();
  buffered_matrixn_colorspace_converter_if #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(6),
    .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(3)) if1 ();
  buffered_matrixn_colorspace_converter_if #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(6),
    .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(5)) if5 ();

  assign if3.pixel = pix;  assign if3.vsync = vsync;  assign if3.data_enable = de;
  assign if1.pixel = pix;  assign if1.vsync = vsync;  assign if1.data_enable = de;
  assign if5.pixel = pix;  assign if5.vsync = vsync;  assign if5.data_enable = de;

  buffered_matrixn_colorspace_converter #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(6),
    .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(3), .P_GRAY_MODE(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .vid(if3));
  buffered_matrixn_colorspace_converter #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(6),
    .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(3), .P_GRAY_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .vid(if1));
  buffered_matrixn_colorspace_converter #(.P_FRAME_COLUMNS(8), .P_FRAME_ROWS(6),
    .P_PIXEL_DEPTH(24), .P_MATRIX_SIZE(5), .P_GRAY_MODE(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .vid(if5));

  always @(negedge clk) begin
    if (if3.pixel_matrix_ready)
      q3.push_back({8'(if3.pixel_row), 8'(if3.pixel_column), 256'(if3.pixel_matrix)});
    if (if1.pixel_matrix_ready)
      q1.push_back({8'(if1.pixel_row), 8'(if1.pixel_column), 256'(if1.pixel_matrix)});
    if (if5.pixel_matrix_ready)
      q5.push_back({8'(if5.pixel_row), 8'(if5.pixel_column), 256'(if5.pixel_matrix)});
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mode 0 with R=G=B=v yields floor(255v/256) = v-1 for 1<=v<=256, so v=g+1 gives gray g.
  function automatic logic [23:0] px_of(input int g);
    logic [7:0] v;
    v = 8'(g + 1);
    return {v, v, v};
  endfunction

  // Row-major window, top-left in MSBs; flat>=0 gives a uniform window, else gray = r*8+c.
  function automatic logic [255:0] exp_mat(input int n, input int r0, input int c0, input int flat);
    logic [255:0] m;
    m = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        if (!CENTER && r == n / 2 && c == n / 2) continue;
        m = (m << 8) | 256'((flat >= 0) ? flat : (r0 + r) * 8 + (c0 + c));
      end
    return m;
  endfunction

  task automatic clear_q();
    q3.delete(); q1.delete(); q5.delete();
  endtask

  task automatic vs_pulse();
    @(negedge clk); vsync = 1'b1; de = 1'b0;
    @(negedge clk); vsync = 1'b0;
  endtask

  task automatic grad_line(input int row, input int npx);
    for (int c = 0; c < npx; c++) begin
      @(negedge clk); de = 1'b1;
      pix = (c < 8) ? px_of(row * 8 + c) : 24'hFFFFFF;
    end
    @(negedge clk); de = 1'b0;
    @(negedge clk);
  endtask

  task automatic flat_line(input logic [23:0] color);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); de = 1'b1; pix = color;
    end
    @(negedge clk); de = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, 256'(if3.pixel_matrix_ready), '0);
    chk({tag, "_col"}, 256'(if3.pixel_column), '0);
    chk({tag, "_row"}, 256'(if3.pixel_row), '0);
    chk({tag, "_mat"}, 256'(if3.pixel_matrix), '0);
  endtask

  initial begin
    logic [23:0] colors [3];
    int          grays1 [3];
    colors[0] = 24'hFF0000; colors[1] = 24'h00FF00; colors[2] = 24'hFFFFFF;
    grays1[0] = 76;  grays1[1] = 149; grays1[2] = 255;  // 77*255>>8, 150*255>>8, 256*255>>8

    // Reset with DE toggling and no VSYNC
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); de = i[0]; pix = px_of(i + 3);
    end
    chk_zero("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); de = i[0]; pix = px_of(i);
    end
    @(negedge clk); de = 1'b0;
    drain();
    chk("novs_q3", 256'(q3.size()), 0);
    chk("novs_q5", 256'(q5.size()), 0);
    chk_zero("novs");

    // Full gradient frame
    clear_q();
    vs_pulse();
    for (int r = 0; r < 6; r++) grad_line(r, 8);
    drain();
    chk("f1_cnt", 256'(q3.size()), 24);
    for (int i = 0; i < q3.size() && i < 24; i++) begin
      chk($sformatf("f1_row%0d", i), 256'(q3[i].row), 256'(i / 6));
      chk($sformatf("f1_col%0d", i), 256'(q3[i].col), 256'(i % 6));
      chk($sformatf("f1_mat%0d", i), q3[i].mat, exp_mat(3, i / 6, i % 6, -1));
    end
`ifndef CENTER_PIXEL_EN
    if (q3.size() == 24) begin
      chk("f1_first", q3[0].mat, 256'({8'd0, 8'd1, 8'd2, 8'd8, 8'd10, 8'd16, 8'd17, 8'd18}));
      chk("f1_last", q3[23].mat, 256'({8'd29, 8'd30, 8'd31, 8'd37, 8'd39, 8'd45, 8'd46, 8'd47}));
    end
`endif
    chk("hold_col", 256'(if3.pixel_column), 5);
    chk("hold_row", 256'(if3.pixel_row), 3);
    chk("hold_mat", 256'(if3.pixel_matrix), exp_mat(3, 3, 5, -1));
    chk("n5_cnt", 256'(q5.size()), 8);
    if (q5.size() == 8) begin
      chk("n5_first_rc", {q5[0].row, q5[0].col}, 0);
      chk("n5_first_mat", q5[0].mat, exp_mat(5, 0, 0, -1));
      chk("n5_last_rc", {q5[7].row, q5[7].col}, 256'({8'd1, 8'd3}));
      chk("n5_last_mat", q5[7].mat, exp_mat(5, 1, 3, -1));
    end

    // Mode 1 weights on flat frames (mode 0 reference: 765*85>>8 style)
    for (int k = 0; k < 3; k++) begin
      clear_q();
      vs_pulse();
      for (int r = 0; r < 3; r++) flat_line(colors[k]);
      drain();
      chk($sformatf("m1_cnt%0d", k), 256'(q1.size()), 6);
      if (q1.size() == 6) begin
        chk($sformatf("m1_first%0d", k), q1[0].mat, exp_mat(3, 0, 0, grays1[k]));
        chk($sformatf("m1_last%0d", k), q1[5].mat, exp_mat(3, 0, 0, grays1[k]));
      end
      if (k == 0 && q3.size() > 0)
        chk("m0_red", q3[0].mat, exp_mat(3, 0, 0, 84));  // 255*85>>8
    end

    // Overlong line: pixels 8 and 9 must be dropped
    clear_q();
    vs_pulse();
    grad_line(0, 10);
    grad_line(1, 8);
    grad_line(2, 8);
    drain();
    chk("ovf_cnt", 256'(q3.size()), 6);
    for (int i = 0; i < q3.size() && i < 6; i++) begin
      chk($sformatf("ovf_rc%0d", i), {q3[i].row, q3[i].col}, 256'(i));
      chk($sformatf("ovf_mat%0d", i), q3[i].mat, exp_mat(3, 0, i, -1));
    end

    // VSYNC in the middle of line 3, with DE high on that cycle
    clear_q();
    vs_pulse();
    for (int r = 0; r < 3; r++) grad_line(r, 8);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); de = 1'b1; pix = px_of(24 + c);
    end
    @(negedge clk); vsync = 1'b1; de = 1'b1; pix = 24'hFFFFFF;
    @(negedge clk); vsync = 1'b0; de = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 3; r++) grad_line(r, 8);
    drain();
    chk("vs_cnt", 256'(q3.size()), 14);
    if (q3.size() == 14) begin
      chk("vs_part0_rc", {q3[6].row, q3[6].col}, 256'({8'd1, 8'd0}));
      chk("vs_part1_mat", q3[7].mat, exp_mat(3, 1, 1, -1));
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("vs_new_rc%0d", i), {q3[8+i].row, q3[8+i].col}, 256'(i));
        chk($sformatf("vs_new_mat%0d", i), q3[8+i].mat, exp_mat(3, 0, i, -1));
      end
    end

    // Reset mid-frame: nothing until the next VSYNC
    clear_q();
    vs_pulse();
    grad_line(0, 8);
    grad_line(1, 8);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); de = 1'b1; pix = px_of(16 + c);
    end
    rst_n = 1'b0;
    @(negedge clk); de = 1'b0;
    chk_zero("mrst");
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) grad_line(r, 8);
    drain();
    chk("mrst_novs_cnt", 256'(q3.size()), 0);
    vs_pulse();
    for (int r = 0; r < 3; r++) grad_line(r, 8);
    drain();
    chk("mrst_vs_cnt", 256'(q3.size()), 6);
    if (q3.size() == 6)
      chk("mrst_vs_mat", q3[0].mat, exp_mat(3, 0, 0, -1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
